// File: rtl/id_pipe_stage.sv
// id_pipe_stage: RV32 decode stage with register file, immediate generation, operand bypass,
// hazard detection and the ID/EX register. Define ID_FWD_EN to enable EX/MEM forwarding with load-use stalls.

module id_opnd_sel #(
    parameter int XLEN = 32
) (
    input  logic [4:0]      rs,
    input  logic [XLEN-1:0] rf_val,
    input  logic            ex_we,
    input  logic [4:0]      ex_rd,
    input  logic [XLEN-1:0] ex_fwd,
    input  logic            mem_we,
    input  logic [4:0]      mem_rd,
    input  logic [XLEN-1:0] mem_fwd,
    input  logic            wb_we,
    input  logic [4:0]      wb_rd,
    input  logic [XLEN-1:0] wb_wd,
    output logic            ex_hit,
    output logic            mem_hit,
    output logic [XLEN-1:0] opnd
);
    logic wb_hit;

    always_comb begin
        ex_hit  = (rs != 5'd0) && ex_we  && (ex_rd  == rs);
        mem_hit = (rs != 5'd0) && mem_we && (mem_rd == rs);
        wb_hit  = (rs != 5'd0) && wb_we  && (wb_rd  == rs);
    end

`ifdef ID_FWD_EN
    always_comb begin
        opnd = rf_val;
        if (rs == 5'd0)   opnd = '0;
        else if (ex_hit)  opnd = ex_fwd;
        else if (mem_hit) opnd = mem_fwd;
        else if (wb_hit)  opnd = wb_wd;
    end
`else
    // Without bypass, EX/MEM results are never selected; only WB write-through remains.
    logic unused_fwd;
    assign unused_fwd = ^{ex_fwd, mem_fwd};

    always_comb begin
        opnd = rf_val;
        if (rs == 5'd0)  opnd = '0;
        else if (wb_hit) opnd = wb_wd;
    end
`endif
endmodule

module id_pipe_stage #(
    parameter int XLEN = 32,
    parameter int NREG = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            if_valid,
    input  logic [31:0]     if_inst,
    input  logic [XLEN-1:0] if_pc,
    input  logic [2:0]      sext_op,
    input  logic            rs1_used,
    input  logic            rs2_used,
    input  logic            rd_we,
    input  logic            flush,
    input  logic            ex_we,
    input  logic            ex_is_load,
    input  logic [4:0]      ex_rd,
    input  logic [XLEN-1:0] ex_fwd,
    input  logic            mem_we,
    input  logic [4:0]      mem_rd,
    input  logic [XLEN-1:0] mem_fwd,
    input  logic            wb_we,
    input  logic [4:0]      wb_rd,
    input  logic [XLEN-1:0] wb_wd,
    output logic            id_stall,
    output logic            idex_valid,
    output logic [XLEN-1:0] idex_pc,
    output logic [XLEN-1:0] idex_rd1,
    output logic [XLEN-1:0] idex_rd2,
    output logic [XLEN-1:0] idex_imm,
    output logic [4:0]      idex_rd,
    output logic [4:0]      idex_rs1,
    output logic [4:0]      idex_rs2,
    output logic            idex_rd_we
);
    localparam int         RW     = $clog2(NREG);
    localparam logic [5:0] NREG_L = 6'(NREG);

    logic [NREG-1:0][XLEN-1:0] rf_q, rf_d;
    logic [1:0][4:0]           rs_idx;
    logic [1:0]                rs_use;
    logic [1:0][XLEN-1:0]      rf_rd;
    logic [1:0][XLEN-1:0]      opnd;
    logic [1:0]                ex_hit, mem_hit;
    logic [31:0]               imm32;
    logic [XLEN-1:0]           imm_ext;

    logic                      valid_q, valid_d;
    logic                      rd_we_q, rd_we_d;
    logic [XLEN-1:0]           pc_q, pc_d;
    logic [XLEN-1:0]           rd1_q, rd1_d;
    logic [XLEN-1:0]           rd2_q, rd2_d;
    logic [XLEN-1:0]           imm_q, imm_d;
    logic [4:0]                rd_q, rd_d;
    logic [4:0]                rs1_q, rs1_d;
    logic [4:0]                rs2_q, rs2_d;

    logic unused_opc;
    assign unused_opc = ^if_inst[6:0];

    assign rs_idx = {if_inst[24:20], if_inst[19:15]};
    assign rs_use = {rs2_used, rs1_used};

    always_comb begin
        rf_d = rf_q;
        if (wb_we && (wb_rd != 5'd0) && ({1'b0, wb_rd} < NREG_L))
            rf_d[wb_rd[RW-1:0]] = wb_wd;
    end

    for (genvar i = 0; i < 2; i++) begin : g_src
        // Indices beyond the implemented file (RV32E) read as zero.
        assign rf_rd[i] = ({1'b0, rs_idx[i]} < NREG_L) ? rf_q[rs_idx[i][RW-1:0]] : '0;

        id_opnd_sel #(.XLEN(XLEN)) u_sel (
            .rs      (rs_idx[i]),
            .rf_val  (rf_rd[i]),
            .ex_we   (ex_we),
            .ex_rd   (ex_rd),
            .ex_fwd  (ex_fwd),
            .mem_we  (mem_we),
            .mem_rd  (mem_rd),
            .mem_fwd (mem_fwd),
            .wb_we   (wb_we),
            .wb_rd   (wb_rd),
            .wb_wd   (wb_wd),
            .ex_hit  (ex_hit[i]),
            .mem_hit (mem_hit[i]),
            .opnd    (opnd[i])
        );
    end

`ifdef ID_FWD_EN
    logic load_use;
    logic unused_mem_hit;
    assign unused_mem_hit = ^mem_hit;
    assign load_use = if_valid && ex_is_load && |(rs_use & ex_hit);
    assign id_stall = load_use && !flush;
`else
    // Any in-flight producer in EX or MEM blocks the consumer until it reaches WB.
    logic unused_ld;
    assign unused_ld = ex_is_load;
    assign id_stall  = if_valid && !flush && |(rs_use & (ex_hit | mem_hit));
`endif

    always_comb begin
        imm32 = '0;
        case (sext_op)
            3'd0: imm32 = {{20{if_inst[31]}}, if_inst[31:20]};
            3'd1: imm32 = {{20{if_inst[31]}}, if_inst[31:25], if_inst[11:7]};
            3'd2: imm32 = {{19{if_inst[31]}}, if_inst[31], if_inst[7], if_inst[30:25],
                           if_inst[11:8], 1'b0};
            3'd3: imm32 = {if_inst[31:12], 12'b0};
            3'd4: imm32 = {{11{if_inst[31]}}, if_inst[31], if_inst[19:12], if_inst[20],
                           if_inst[30:21], 1'b0};
            3'd5: imm32 = {27'b0, if_inst[24:20]};
            default: imm32 = '0;
        endcase
        // shamt has bit 31 clear, so sign extension leaves it zero-extended.
        imm_ext = XLEN'(signed'(imm32));
    end

    always_comb begin
        valid_d = valid_q;
        rd_we_d = rd_we_q;
        pc_d    = pc_q;
        rd1_d   = rd1_q;
        rd2_d   = rd2_q;
        imm_d   = imm_q;
        rd_d    = rd_q;
        rs1_d   = rs1_q;
        rs2_d   = rs2_q;
        if (flush || id_stall) begin
            valid_d = 1'b0;
            rd_we_d = 1'b0;
        end else begin
            valid_d = if_valid;
            rd_we_d = rd_we && if_valid;
            pc_d    = if_pc;
            rd1_d   = opnd[0];
            rd2_d   = opnd[1];
            imm_d   = imm_ext;
            rd_d    = if_inst[11:7];
            rs1_d   = rs_idx[0];
            rs2_d   = rs_idx[1];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rf_q    <= '0;
            valid_q <= 1'b0;
            rd_we_q <= 1'b0;
            pc_q    <= '0;
            rd1_q   <= '0;
            rd2_q   <= '0;
            imm_q   <= '0;
            rd_q    <= '0;
            rs1_q   <= '0;
            rs2_q   <= '0;
        end else begin
            rf_q    <= rf_d;
            valid_q <= valid_d;
            rd_we_q <= rd_we_d;
            pc_q    <= pc_d;
            rd1_q   <= rd1_d;
            rd2_q   <= rd2_d;
            imm_q   <= imm_d;
            rd_q    <= rd_d;
            rs1_q   <= rs1_d;
            rs2_q   <= rs2_d;
        end
    end

    assign idex_valid = valid_q;
    assign idex_rd_we = rd_we_q;
    assign idex_pc    = pc_q;
    assign idex_rd1   = rd1_q;
    assign idex_rd2   = rd2_q;
    assign idex_imm   = imm_q;
    assign idex_rd    = rd_q;
    assign idex_rs1   = rs1_q;
    assign idex_rs2   = rs2_q;
endmodule

// File: doc/id_pipe_stage.md
# id_pipe_stage

Parametrised decode stage for the pipelined RV32 core. It is the successor to the single-cycle decode logic: register file, immediate generation, and a registered ID/EX boundary. Register width and count are parameters, and writeback now arrives from a separate WB stage. It adds EX/MEM/WB operand forwarding, load-use hazard detection with a stall/bubble, and flush on redirect. It sits between the IF/ID register (owned by IF) and the EX stage.

## Interface
- XLEN, 32, data width; 32 or 64; immediates sign-extend to XLEN
- NREG, 32, architectural registers; 32 (RV32I) or 16 (RV32E)
- clk  in  1  clock, all state updates on rising edge
- rst_n  in  1  asynchronous, active-low reset
- if_valid  in  1  if_inst/if_pc hold a real instruction
- if_inst  in  32  instruction word
- if_pc  in  XLEN  instruction PC
- sext_op  in  3  immediate type from controller
- rs1_used, rs2_used  in  1 each  instruction reads rs1/rs2
- rd_we  in  1  instruction writes rd (from controller)
- flush  in  1  branch/jump redirect; kill the instruction in ID
- ex_we, ex_is_load  in  1 each  EX-stage instruction writes rd / is a load
- ex_rd  in  5  EX-stage destination
- ex_fwd  in  XLEN  EX ALU result
- mem_we  in  1  MEM-stage instruction writes rd
- mem_rd  in  5  MEM-stage destination
- mem_fwd  in  XLEN  MEM final result, including load data
- wb_we  in  1  writeback enable
- wb_rd  in  5  writeback destination
- wb_wd  in  XLEN  writeback data
- id_stall  out  1  combinational; IF must hold PC and IF/ID
- idex_valid  out  1  registered; ID/EX holds a real instruction
- idex_pc, idex_rd1, idex_rd2, idex_imm  out  XLEN each  registered operands
- idex_rd, idex_rs1, idex_rs2  out  5 each  registered indices
- idex_rd_we  out  1  registered rd_we, gated by validity

## Operation
- **Fields**
  - rs1 = inst[19:15], rs2 = inst[24:20], rd = inst[11:7].
- **Immediates** (sext_op)
  - 0 I: inst[31:20]
  - 1 S: {inst[31:25], inst[11:7]}
  - 2 B: {inst[31], inst[7], inst[30:25], inst[11:8], 0}
  - 3 U: {inst[31:12], 12'b0}
  - 4 J: {inst[31], inst[19:12], inst[20], inst[30:21], 0}
  - 5 shamt: zero-extended inst[24:20]
  - 6, 7: 0
  - All non-shamt types sign-extend from inst[31] to XLEN.
- **Register file**
  - x0 reads 0 and ignores writes.
  - A write occurs at the clock edge when wb_we=1 and 0 < wb_rd < NREG.
  - For an index ≥ NREG, reads return 0 and writes are dropped.
- **Operand select** (per source rsN != 0), priority high to low:
  - EX: ex_we && ex_rd == rsN → ex_fwd
  - MEM: mem_we && mem_rd == rsN → mem_fwd
  - WB: wb_we && wb_rd == rsN → wb_wd (write-through)
  - otherwise the RF array.
  - rsN = 0 always yields 0.
- **Hazard**
  - load_use = if_valid && ex_is_load && ex_we && ex_rd != 0 && ((rs1_used && ex_rd == rs1) || (rs2_used && ex_rd == rs2)).
  - id_stall = load_use && !flush.
- **ID/EX update** (every edge), first match wins:
  1. flush: idex_valid←0, idex_rd_we←0.
  2. id_stall: insert a bubble, same as case 1.
  3. Otherwise: idex_valid←if_valid, idex_rd_we←rd_we && if_valid, and all data/index fields load.
- Bubble data fields keep their previous values; consumers must qualify them with idex_valid.
- **Reset**: all idex_* outputs are 0, all registers are 0, and id_stall is 0 when inputs are quiescent.

## Timing
- Operand, immediate, and index latency is 1 cycle: inputs sampled at edge N appear on idex_* after edge N.
- id_stall is combinational in the same cycle. The stalled instruction is re-presented by IF and passes on the next cycle, when its producer is in MEM and is forwarded from mem_fwd.
- A write and a read of the same register in the same cycle yields the new data.
- flush and stall in the same cycle: flush wins. id_stall=0 and a bubble is inserted.
- Asserting reset mid-operation clears the pipeline register and the RF immediately, without waiting for clk.

## Configuration
- ID_FWD_EN
  - **Defined**: forwarding and the load-use hazard rule operate as described in Operation.
  - **Undefined**: EX and MEM bypass paths are removed; WB write-through stays.
    - id_stall = if_valid && !flush && any used rsN != 0 matching (ex_we && ex_rd) or (mem_we && mem_rd).
    - Dependent instructions therefore wait for their producer to reach WB.

## Test plan
- **Reset**: rst_n=0 mid-run → all idex_* = 0 immediately; after release, reading x5 returns 0.
- **Immediates**: inst 0xFFF00093 with sext_op=0 → idex_imm = 0xFFFFFFFF. J-type 0x8000006F with sext_op=4 → idex_imm = 0xFFF00000.
- **Forward priority**: rs1=x3; ex_we=1, ex_rd=3, ex_fwd=0x11; mem_we=1, mem_rd=3, mem_fwd=0x22 → idex_rd1 = 0x11. With ex_we=0 → 0x22. With both cleared and wb_rd=3, wb_wd=0x33 → 0x33.
- **Load-use**: ex_is_load=1, ex_rd=5, rs2=x5, rs2_used=1 → id_stall=1 and the next idex_valid=0. The following cycle with mem_rd=5, mem_fwd=0xAB → idex_rd2 = 0xAB, valid=1.
- **Flush/x0**: flush with load_use asserted → id_stall=0, idex_valid=0. wb write to x0 of 0xDEAD → reads of x0 return 0.
- **No-forward build** (ID_FWD_EN undefined): ALU dependency with ex_rd = rs1 → id_stall held 2 cycles until the producer reaches WB, then correct data via write-through.
